flop_write_arbiter: RTL and testbench
=====================================

// Module: flop_write_arbiter
// PURPOSE
// - Round-robin arbiter and sequencer for one shared WIDTH-bit flip-flop register.
// - N_REQ requesters compete for write access to that register.
// - Grants exclusive ownership to one requester at a time.
// - While the owner holds the grant, its data beats are written into the register.
// - Ownership is released on last-beat, on request drop or on timeout.
// - Sits between the requester blocks and the shared state register.
// PARAMETERS
// - N_REQ     4  number of requesters (>=2)
// - WIDTH     8  width of the shared register and of each requester's data
// - HOLD_MAX  4  max writes per ownership (>=1); used only with FLOP_ARB_TIMEOUT_EN
// PORTS
// - clock   in   1              rising-edge clock
// - reset   in   1              asynchronous, active-high reset
// - req     in   N_REQ          request / beat-valid, one bit per requester
// - last    in   N_REQ          final-beat marker, qualified by req
// - wdata   in   N_REQ*WIDTH    requester i data in bits [i*WIDTH +: WIDTH]
// - gnt     out  N_REQ          one-hot grant (all zero when idle)
// - owner   out  $clog2(N_REQ)  index of the current or last owner
// - q       out  WIDTH          shared register contents
// - q_wr    out  1              one-cycle strobe: q was updated at this edge
// BEHAVIOUR
// Reset
// - On reset: gnt=0, owner=0, q=0, q_wr=0, state=IDLE, rr_ptr=0, hold_cnt=0.
// - Reset acts immediately, without waiting for a clock edge.
// - Reset mid-ownership drops gnt at once; any in-flight beat is lost.
// FSM: IDLE, OWN
// - IDLE, any req set: pick the first set req[i] scanning cyclically from rr_ptr.
//   - Next edge: gnt[i]=1, owner=i, hold_cnt=0, state=OWN.
//   - Request-to-grant latency: 1 cycle.
// - IDLE, no req: stay in IDLE.
// - OWN, at each edge with req[owner]=1 (a beat):
//   - q <= wdata[owner]; q_wr=1 next cycle; hold_cnt++.
// - OWN, at each edge with req[owner]=0: no write, q holds, q_wr=0.
// Release
// - Release conditions, evaluated at the edge:
//   - req[owner]=0, or
//   - req[owner]&last[owner] (that beat is still written), or
//   - timeout: the write in progress at this edge is the HOLD_MAX-th write.
// - On release: gnt<=0, rr_ptr<=(owner+1) mod N_REQ, state<=IDLE.
// - owner keeps its value after release.
// - Always one IDLE cycle between successive grants; no back-to-back grants.
// Other rules
// - req, last and wdata of non-owners are ignored in OWN.
// - last without req is ignored.
// - q_wr is never 1 unless a write occurred at the preceding edge.
// - Widths: hold_cnt is $clog2(HOLD_MAX+1) bits and saturates; rr_ptr wraps N_REQ-1 -> 0.
// CONFIGURATION
// - Macro FLOP_ARB_TIMEOUT_EN defined:
//   - HOLD_MAX is enforced; the owner is released after exactly HOLD_MAX writes even without last.
// - Macro FLOP_ARB_TIMEOUT_EN undefined:
//   - No timeout; hold_cnt logic is absent.
//   - The owner keeps the grant until last or req drop.
// TESTING
// 1. Reset high 10 ns then low, req=0 -> gnt=0, q=0, q_wr=0 for 10 cycles.
// 2. req=0001, wdata0=A5,3C,7E, last on 3rd beat
//    -> gnt=0001 one cycle after req; q=A5,3C,7E; three q_wr strobes; then gnt=0, rr_ptr=1.
// 3. req=1111 held, last=1111
//    -> grants 0001,0010,0100,1000,0001 in turn, each separated by one gnt=0 cycle.
// 4. FLOP_ARB_TIMEOUT_EN, HOLD_MAX=4, req=0100 held, last=0
//    -> exactly 4 writes, gnt=0 for one cycle, then gnt=0100 again.
//    Without the macro: gnt stays 0100 indefinitely.
// 5. Reset asserted mid-OWN
//    -> gnt=0, q=0, q_wr=0 before the next edge; after release, req=1010 grants requester 1 first.
// 6. Owner 2 drops req mid-ownership
//    -> no write at that edge, q unchanged; gnt=0 next cycle; req=1001 then grants requester 3.

Source files
------------

// File: rtl/flop_write_arbiter_if.sv
// Bundle of requester-side and register-side signals of the shared-register write arbiter.
// The master side belongs to the requester blocks; the slave side belongs to the arbiter.
interface flop_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int OWN_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       last;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [OWN_W-1:0]       owner;
  logic [WIDTH-1:0]       q;
  logic                   q_wr;

  modport master (
    output req, last, wdata,
    input  gnt, owner, q, q_wr
  );

  modport slave (
    input  req, last, wdata,
    output gnt, owner, q, q_wr
  );
endinterface

// File: rtl/flop_write_arbiter.sv
// Round-robin owner arbitration and beat sequencing for one shared WIDTH-bit register.
// Optional feature macro FLOP_ARB_TIMEOUT_EN: releases the owner after HOLD_MAX writes.
module flop_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input logic             clock,
  input logic             reset,
  flop_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || HOLD_MAX < 1) begin : g_param_check
    $error("flop_write_arbiter: N_REQ must be >= 2 and HOLD_MAX >= 1");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;

  logic [WIDTH-1:0] wdata_arr [N_REQ];
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             beat;
  logic             timeout;
  logic             release_own;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      wdata_arr[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Cyclic scan starting at rr_ptr; the first set request wins.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_valid && bus.req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
  end

  assign beat        = bus.req[bus.owner];
  assign next_ptr    = (bus.owner == PTR_W'(N_REQ - 1)) ? '0 : bus.owner + 1'b1;
  assign release_own = !beat || bus.last[bus.owner] || timeout;

`ifdef FLOP_ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(HOLD_MAX + 1);

  logic [HC_W-1:0] hold_cnt;

  // The beat at this edge is the HOLD_MAX-th write of the current ownership.
  assign timeout = beat && (hold_cnt == HC_W'(HOLD_MAX - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      bus.gnt   <= '0;
      bus.owner <= '0;
      bus.q     <= '0;
      bus.q_wr  <= 1'b0;
`ifdef FLOP_ARB_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      bus.q_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.gnt   <= N_REQ'(1) << pick_idx;
            bus.owner <= pick_idx;
            state     <= OWN;
`ifdef FLOP_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        OWN: begin
          if (beat) begin
            bus.q    <= wdata_arr[bus.owner];
            bus.q_wr <= 1'b1;
`ifdef FLOP_ARB_TIMEOUT_EN
            if (hold_cnt != HC_W'(HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
`endif
          end
          // owner is deliberately left untouched so it reports the last owner while idle.
          if (release_own) begin
            bus.gnt <= '0;
            rr_ptr  <= next_ptr;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flop_write_arbiter.sv
// Randomised and directed stimulus for flop_write_arbiter; a transaction-level model
// predicts grant, write and release events that a separate monitor checks against the DUT.
module tb_flop_write_arbiter;
  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 4;
`ifdef FLOP_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  flop_write_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  flop_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t wr_q[$];
  ev_t gr_q[$];
  ev_t rl_q[$];

  // Reference model: current owner (-1 when idle), next scan start, writes this ownership.
  int m_own    = -1;
  int m_ptr    = 0;
  int m_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predicts what the coming clock edge does with these inputs.
  task automatic model_edge(input logic [3:0] r, input logic [3:0] l, input logic [31:0] w);
    int  stamp;
    bit  found;
    bit  beat;
    bit  rel;
    stamp = cyc + 1;
    if (m_own < 0) begin
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (m_ptr + k) % N_REQ;
        if (!found && r[i]) begin
          found    = 1'b1;
          m_own    = i;
          m_writes = 0;
          gr_q.push_back(ev_t'{stamp, i});
        end
      end
    end else begin
      beat = r[m_own];
      if (beat) begin
        wr_q.push_back(ev_t'{stamp, int'(w[m_own*WIDTH +: WIDTH])});
        m_writes++;
      end
      rel = !beat || l[m_own] || (TIMEOUT_EN && m_writes == HOLD_MAX);
      if (rel) begin
        rl_q.push_back(ev_t'{stamp, m_own});
        m_ptr = (m_own + 1) % N_REQ;
        m_own = -1;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [31:0] w);
    @(negedge clock);
    bus.req   = r;
    bus.last  = l;
    bus.wdata = w;
    model_edge(r, l, w);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1;
    reset    = 1'b1;
    bus.req  = '0;
    bus.last = '0;
    #1;
    check("reset_gnt", bus.gnt, 0);
    check("reset_q", bus.q, 0);
    check("reset_q_wr", bus.q_wr, 0);
    check("reset_owner", bus.owner, 0);
    wr_q.delete();
    gr_q.delete();
    rl_q.delete();
    m_own    = -1;
    m_ptr    = 0;
    m_writes = 0;
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: consumes expected events whenever the DUT shows a write, grant or release.
  initial begin
    logic [3:0] prev;
    ev_t        e;
    prev = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = '0;
      end else begin
        check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
        if (bus.q_wr) begin
          check("write_expected", 32'(wr_q.size() > 0), 1);
          if (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            check("write_cycle", cyc, e.cyc);
            check("write_data", bus.q, e.val);
          end
        end
        if (bus.gnt != 0 && prev == 0) begin
          check("grant_expected", 32'(gr_q.size() > 0), 1);
          if (gr_q.size() > 0) begin
            e = gr_q.pop_front();
            check("grant_cycle", cyc, e.cyc);
            check("grant_vector", bus.gnt, 32'(1) << e.val);
            check("grant_owner", bus.owner, e.val);
          end
        end else if (bus.gnt == 0 && prev != 0) begin
          check("release_expected", 32'(rl_q.size() > 0), 1);
          if (rl_q.size() > 0) begin
            e = rl_q.pop_front();
            check("release_cycle", cyc, e.cyc);
            check("release_owner_kept", bus.owner, e.val);
          end
        end else if (bus.gnt != 0) begin
          check("gnt_stable", bus.gnt, prev);
        end
        prev = bus.gnt;
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [3:0] l;
    bus.req   = '0;
    bus.last  = '0;
    bus.wdata = '0;

    // Reset release with no requests: everything stays quiet.
    #10 reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("idle_gnt", bus.gnt, 0);
      check("idle_q", bus.q, 0);
      check("idle_q_wr", bus.q_wr, 0);
    end

    // Requester 0 writes three beats, last on the third.
    step(4'b0001, 4'b0000, 32'h0000_00A5);
    step(4'b0001, 4'b0000, 32'h0000_00A5);
    step(4'b0001, 4'b0000, 32'h0000_003C);
    step(4'b0001, 4'b0001, 32'h0000_007E);
    step(4'b0000, 4'b0000, 32'h0);
    // rr_ptr now points at requester 1.
    step(4'b1111, 4'b1111, 32'h4433_2211);
    step(4'b1111, 4'b1111, 32'h4433_2211);
    step(4'b0000, 4'b0000, 32'h0);

    // All requesters, single-beat ownerships, from a fresh reset.
    apply_reset();
    repeat (12) step(4'b1111, 4'b1111, $urandom);
    step(4'b0000, 4'b0000, 32'h0);

    // Requester 2 streams without last.
    repeat (14) step(4'b0100, 4'b0000, $urandom);
    repeat (2) step(4'b0000, 4'b0000, 32'h0);

    // Reset in the middle of an ownership, then requesters 1 and 3 compete.
    repeat (3) step(4'b0001, 4'b0000, $urandom);
    apply_reset();
    repeat (3) step(4'b1010, 4'b0000, $urandom);
    repeat (2) step(4'b0000, 4'b0000, 32'h0);

    // Owner 2 drops its request mid-ownership.
    apply_reset();
    repeat (3) step(4'b0100, 4'b0000, $urandom);
    step(4'b0000, 4'b0000, $urandom);
    repeat (3) step(4'b1001, 4'b0000, $urandom);
    repeat (2) step(4'b0000, 4'b0000, 32'h0);

    // Random traffic with sticky requests and sparse last markers.
    r = '0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) r = 4'($urandom);
      for (int b = 0; b < N_REQ; b++) l[b] = ($urandom_range(0, 3) == 0);
      step(r, l, $urandom);
    end
    repeat (4) step(4'b0000, 4'b0000, 32'h0);

    @(negedge clock);
    check("writes_drained", wr_q.size(), 0);
    check("grants_drained", gr_q.size(), 0);
    check("releases_drained", rl_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
